// File: rtl/terrain_dig_writer.sv
`default_nettype none
// =============================================================================
// terrain_dig_writer : turns player steps into block-clear writes on the
// terrain bitmap write port and refills the whole map on level restore.
// Revision: 1.0
// =============================================================================
module terrain_dig_writer #(
  parameter int TERRAIN_X0  = 32,
  parameter int TERRAIN_Y0  = 160,
  parameter int TERRAIN_W   = 480,
  parameter int TERRAIN_H   = 320,
  parameter int BLOCK_SHIFT = 3,
  parameter int PLAYER_SIZE = 32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        player_moved,
  input  logic [10:0] playerTLX,
  input  logic [10:0] playerTLY,
  input  logic        level_restore,
  output logic        wr_req,
  output logic [11:0] wr_addr,
  output logic        wr_data,
  input  logic        wr_ack,
  output logic        dig_busy,
  output logic        dig_done
);

  localparam int c_COLS  = TERRAIN_W >> BLOCK_SHIFT;
  localparam int c_ROWS  = TERRAIN_H >> BLOCK_SHIFT;
  localparam int c_DEPTH = c_COLS * c_ROWS;
  localparam int c_CW    = $clog2(c_COLS);
  localparam int c_RW    = $clog2(c_ROWS);

  localparam logic [11:0] c_X0        = 12'(TERRAIN_X0);
  localparam logic [11:0] c_Y0        = 12'(TERRAIN_Y0);
  localparam logic [11:0] c_X_LAST    = 12'(TERRAIN_X0 + TERRAIN_W - 1);
  localparam logic [11:0] c_Y_LAST    = 12'(TERRAIN_Y0 + TERRAIN_H - 1);
  localparam logic [11:0] c_SPAN      = 12'(PLAYER_SIZE - 1);
  localparam logic [11:0] c_COLS12    = 12'(c_COLS);
  localparam logic [11:0] c_LAST_ADDR = 12'(c_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_FILL  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       px_q, px_d, py_q, py_d;
  logic [10:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic              pend_move_q, pend_move_d;
  logic              restore_q, restore_d;
  logic [c_CW-1:0]   col_q, col_d, col_s_q, col_s_d, col_e_q, col_e_d;
  logic [c_RW-1:0]   row_q, row_d, row_e_q, row_e_d;
  logic [11:0]       fill_q, fill_d;

  logic [11:0] w_px, w_py, w_px_end, w_py_end;
  logic [11:0] w_x0, w_x1, w_y0, w_y1;
  logic [11:0] w_x_off0, w_x_off1, w_y_off0, w_y_off1;
  logic [11:0] w_dig_addr;
  logic        w_empty;
  logic        w_xfer;

  // Clipped player box; 12-bit math keeps px + PLAYER_SIZE - 1 from wrapping.
  always_comb begin
    w_px     = {1'b0, px_q};
    w_py     = {1'b0, py_q};
    w_px_end = w_px + c_SPAN;
    w_py_end = w_py + c_SPAN;
    w_x0     = (w_px > c_X0) ? w_px : c_X0;
    w_y0     = (w_py > c_Y0) ? w_py : c_Y0;
    w_x1     = (w_px_end < c_X_LAST) ? w_px_end : c_X_LAST;
    w_y1     = (w_py_end < c_Y_LAST) ? w_py_end : c_Y_LAST;
    w_empty  = (w_x0 > w_x1) || (w_y0 > w_y1);
    w_x_off0 = w_x0 - c_X0;
    w_x_off1 = w_x1 - c_X0;
    w_y_off0 = w_y0 - c_Y0;
    w_y_off1 = w_y1 - c_Y0;
  end

  always_comb begin
    w_dig_addr = 12'(row_q) * c_COLS12 + 12'(col_q);
    wr_req     = (state_q == S_ISSUE) || (state_q == S_FILL);
    wr_data    = (state_q == S_FILL);
    dig_busy   = (state_q != S_IDLE);
    dig_done   = (state_q == S_DONE);
    if (state_q == S_ISSUE) begin
      wr_addr = w_dig_addr;
    end else if (state_q == S_FILL) begin
      wr_addr = fill_q;
    end else begin
      wr_addr = 12'd0;
    end
    w_xfer = wr_req && wr_ack;
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_move_d = pend_move_q;
    restore_d   = restore_q;
    col_d       = col_q;
    row_d       = row_q;
    col_s_d     = col_s_q;
    col_e_d     = col_e_q;
    row_e_d     = row_e_q;
    fill_d      = fill_q;

    // Requests arriving while a sweep runs are parked; newest move wins.
    if (state_q != S_IDLE) begin
      if (player_moved) begin
        pend_move_d = 1'b1;
        pend_x_d    = playerTLX;
        pend_y_d    = playerTLY;
      end
      if (level_restore) begin
        restore_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (level_restore || restore_q) begin
          state_d   = S_FILL;
          restore_d = 1'b0;
          fill_d    = 12'd0;
          if (player_moved) begin
            pend_move_d = 1'b1;
            pend_x_d    = playerTLX;
            pend_y_d    = playerTLY;
          end
        end else if (player_moved) begin
          state_d     = S_CALC;
          px_d        = playerTLX;
          py_d        = playerTLY;
          pend_move_d = 1'b0;
        end else if (pend_move_q) begin
          state_d     = S_CALC;
          px_d        = pend_x_q;
          py_d        = pend_y_q;
          pend_move_d = 1'b0;
        end
      end
      S_CALC: begin
        if (w_empty) begin
          state_d = S_DONE;
        end else begin
          col_s_d = c_CW'(w_x_off0 >> BLOCK_SHIFT);
          col_e_d = c_CW'(w_x_off1 >> BLOCK_SHIFT);
          row_e_d = c_RW'(w_y_off1 >> BLOCK_SHIFT);
          col_d   = c_CW'(w_x_off0 >> BLOCK_SHIFT);
          row_d   = c_RW'(w_y_off0 >> BLOCK_SHIFT);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_xfer) begin
          if (col_q == col_e_q) begin
            if (row_q == row_e_q) begin
              state_d = S_DONE;
            end else begin
              col_d = col_s_q;
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        if (w_xfer) begin
          if (fill_q == c_LAST_ADDR) begin
            state_d = S_DONE;
            fill_d  = 12'd0;
          end else begin
            fill_d = fill_q + 12'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_move_q <= 1'b0;
      restore_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      col_s_q     <= '0;
      col_e_q     <= '0;
      row_e_q     <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_move_q <= pend_move_d;
      restore_q   <= restore_d;
      col_q       <= col_d;
      row_q       <= row_d;
      col_s_q     <= col_s_d;
      col_e_q     <= col_e_d;
      row_e_q     <= row_e_d;
      fill_q      <= fill_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_terrain_dig_writer.sv
`default_nettype none
// tb_terrain_dig_writer : directed vectors for the terrain dig/fill writer.
module tb_terrain_dig_writer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        player_moved = 1'b0;
  logic [10:0] playerTLX = '0;
  logic [10:0] playerTLY = '0;
  logic        level_restore = 1'b0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic        wr_data;
  logic        dig_busy;
  logic        dig_done;

  terrain_dig_writer dut (
    .clk          (clk),
    .resetN       (resetN),
    .player_moved (player_moved),
    .playerTLX    (playerTLX),
    .playerTLY    (playerTLY),
    .level_restore(level_restore),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .dig_busy     (dig_busy),
    .dig_done     (dig_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wa[$];
  int wd[$];
  int exp_q[$];

  always @(negedge clk) begin
    if (resetN && wr_req && wr_ack) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_move(input int x, input int y);
    playerTLX    = 11'(x);
    playerTLY    = 11'(y);
    player_moved = 1'b1;
    tick();
    player_moved = 1'b0;
  endtask

  task automatic pulse_restore();
    level_restore = 1'b1;
    tick();
    level_restore = 1'b0;
  endtask

  int cyc, first_req, done_cyc, idle_cyc, done_cnt;

  // Starts in the cycle-1 window after a trigger pulse.
  task automatic track(input int want_done, input int budget, input int stall_after);
    logic        stalled;
    logic [11:0] sa;
    stalled   = 1'b0;
    cyc       = 1;
    first_req = -1;
    done_cyc  = -1;
    idle_cyc  = -1;
    done_cnt  = 0;
    while (cyc <= budget) begin
      if (wr_req && first_req < 0) first_req = cyc;
      if (dig_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!dig_busy && done_cnt >= want_done) begin
        idle_cyc = cyc;
        break;
      end
      if (stall_after >= 0 && !stalled && wr_req && wa.size() == stall_after) begin
        stalled = 1'b1;
        sa      = wr_addr;
        wr_ack  = 1'b0;
        repeat (3) begin
          tick();
          cyc++;
          chk("stall_req", wr_req, 1);
          chk("stall_addr", wr_addr, sa);
          chk("stall_data", wr_data, 0);
        end
        wr_ack = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("idle_reached", idle_cyc >= 0, 1);
  endtask

  task automatic build(input int rs, input int re, input int cs, input int ce);
    exp_q.delete();
    for (int r = rs; r <= re; r++)
      for (int c = cs; c <= ce; c++)
        exp_q.push_back(r * 60 + c);
  endtask

  task automatic chk_writes(input string tag);
    int bad_data;
    bad_data = 0;
    chk({tag, "_count"}, wa.size(), exp_q.size());
    for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa[i], exp_q[i]);
      if (wd[i] != 0) bad_data++;
    end
    chk({tag, "_data_nonzero"}, bad_data, 0);
  endtask

  task automatic dig_test(input int x, input int y, input int stall_after);
    wa.delete();
    wd.delete();
    pulse_move(x, y);
    chk("busy_rise", dig_busy, 1);
    track(1, 300, stall_after);
  endtask

  initial begin
    int bad;
    int busy_seen;

    // Reset state
    repeat (3) tick();
    chk("rst_req", wr_req, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", dig_busy, 0);
    chk("rst_done", dig_done, 0);
    resetN = 1'b1;
    wr_ack = 1'b1;
    tick();

    // Aligned dig: 4x4 blocks from the terrain origin
    dig_test(32, 160, -1);
    build(0, 3, 0, 3);
    chk_writes("aligned");
    chk("aligned_first_req", first_req, 2);
    chk("aligned_done_cyc", done_cyc, 18);
    chk("aligned_idle_cyc", idle_cyc, 19);
    tick();

    // Unaligned dig with a 3-cycle stall after 10 writes
    dig_test(36, 164, 10);
    build(0, 4, 0, 4);
    chk_writes("unaligned_stall");
    chk("unaligned_last", wa.size() > 0 ? wa[wa.size()-1] : -1, 244);
    tick();

    // Left clip
    dig_test(16, 160, -1);
    build(0, 3, 0, 1);
    chk_writes("clip_left");
    tick();

    // Fully clipped
    dig_test(600, 100, -1);
    chk("clip_all_count", wa.size(), 0);
    chk("clip_all_req", first_req, -1);
    chk("clip_all_done_cyc", done_cyc, 2);
    tick();

    // Bottom-right corner
    dig_test(500, 470, -1);
    build(38, 39, 58, 59);
    chk_writes("clip_corner");
    tick();

    // Coalescing and priority: two moves then a restore while digging
    wa.delete();
    wd.delete();
    pulse_move(32, 160);
    pulse_move(64, 192);
    pulse_move(96, 224);
    pulse_restore();
    track(3, 3000, -1);
    chk("coal_total", wa.size(), 16 + 2400 + 16);
    if (wa.size() == 2432) begin
      bad = 0;
      for (int i = 0; i < 2400; i++)
        if (wa[16+i] != i || wd[16+i] != 1) bad++;
      chk("coal_fill_bad", bad, 0);
      chk("coal_fill_last", wa[2415], 2399);
      // (96,224) -> cols 8..11, rows 8..11
      chk("coal_dig_first", wa[2416], 488);
      chk("coal_dig_last", wa[2431], 671);
      chk("coal_dig_data", wd[2416], 0);
    end
    tick();

    // Reset in the middle of a fill, with work pending
    wa.delete();
    wd.delete();
    pulse_restore();
    chk("fill_req_c1", wr_req, 1);
    chk("fill_data_c1", wr_data, 1);
    chk("fill_addr_c1", wr_addr, 0);
    pulse_move(200, 300);
    pulse_restore();
    cyc = 0;
    while (wa.size() < 1000 && cyc < 1200) begin
      tick();
      cyc++;
    end
    chk("fill_reached_1000", wa.size(), 1000);
    chk("fill_addr_999", wa.size() >= 1000 ? wa[999] : -1, 999);
    resetN = 1'b0;
    #1;
    chk("arst_req", wr_req, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_busy", dig_busy, 0);
    chk("arst_done", dig_done, 0);
    repeat (2) tick();
    resetN = 1'b1;
    wa.delete();
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (dig_busy || wr_req) busy_seen++;
    end
    chk("post_rst_busy", busy_seen, 0);
    chk("post_rst_writes", wa.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
